decoder_scan_driver: RTL
========================

Name: decoder_scan_driver

Overview:
- Sequential upstream stage for the 3-to-8 decoder. Generates the decoder's 3-bit select X and enable En.
- Steps X through 0..7. Each select is held enabled for a programmable dwell time.
- Supports continuous scanning and single-sweep modes.
- Typical use: LED/digit scanning, with the decoder's one-hot output driving the row or digit lines.

Parameters:
- DWELL_W, 8, width of the dwell input and the internal dwell counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
- stop  input  1  abort request; honoured in any non-IDLE state.
- mode  input  1  0 = continuous scan (wraps 7->0 forever); 1 = single sweep 0..7, then stop.
- dwell  input  DWELL_W  cycles each select is enabled; 0 is treated as 1; sampled on accepted start only.
- X  output  3  decoder select, registered.
- En  output  1  decoder enable, registered.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse when a single sweep completes normally.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is asynchronous and active-high. Asserting rst immediately forces IDLE, X=0, En=0, busy=0, done=0, dwell counter=0. This also applies mid-scan. No done pulse is produced by reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, ACTIVE, BLANK (BLANK exists only with the optional feature).
- IDLE:
  - X=0, En=0.
  - If start=1 and stop=0, the next edge enters ACTIVE with X=0, En=1 and busy=1.
  - On that edge, mode is latched and dwell is latched as max(dwell,1).
  - If start and stop are both high, stop wins and the block stays in IDLE.
- ACTIVE:
  - En=1.
  - The dwell counter loads the latched dwell-1 on entry and decrements each cycle. The segment ends in the cycle the counter reads 0.
  - Result: En is high for exactly max(dwell,1) consecutive cycles for each X value.
- End of segment, X<7: X increments; the next state is ACTIVE (or BLANK if the feature is enabled).
- End of segment, X=7, mode=0: X wraps to 0 and scanning continues without interruption.
- End of segment, X=7, mode=1:
  - The next edge enters IDLE with X=0, En=0 and busy=0.
  - done=1 for exactly that one cycle.
- stop in ACTIVE or BLANK:
  - The next edge enters IDLE with X=0, En=0 and done=0.
  - The current dwell is abandoned.
  - stop has priority over every end-of-segment transition.
- Stability:
  - X changes only at segment boundaries.
  - While En=1, X never changes within a segment (glitch-free select).
- Re-entry: start while busy=1 is ignored. A start presented in the done cycle is honoured, since the state is already IDLE.
- Mode/dwell isolation: changes to mode or dwell while busy have no effect until the next accepted start.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined:
  - Each select change passes through BLANK for exactly 1 cycle with En=0. X already holds the new value during BLANK. Then ACTIVE follows.
  - This includes the 7->0 wrap in continuous mode.
  - No BLANK is inserted before the first select after start, or before IDLE.
  - One full continuous period is 8*max(dwell,1)+8 cycles.
- Not defined:
  - No BLANK state exists. ACTIVE follows ACTIVE directly, and En stays high across select changes.
  - One full period is 8*max(dwell,1) cycles.

Decomposition:
- Shared package (decoder_scan_pkg): SEL_W=3, NUM_SEL=8, LAST_SEL=3'd7, and the state encoding localparams ST_IDLE, ST_ACTIVE, ST_BLANK.
- Natural sub-module: dwell_timer, a DWELL_W-bit down counter.
  - Inputs: load, load_value, enable.
  - Output: expire, high when the count is 0.
  - Uses the same asynchronous active-high rst.
- The FSM, the X register and the done pulse stay in decoder_scan_driver.

Test Plan:
- Reset during ACTIVE: rst=1 with X=5, En=1 -> same cycle (asynchronous) X=0, En=0, busy=0, done=0. Remains IDLE after release until start.
- Continuous mode (mode=0, dwell=3, no macro): start -> En high continuously. X sequence 0,0,0,1,1,1,...,7,7,7,0, i.e. 24-cycle period. done never asserts.
- Single sweep (mode=1, dwell=2): start -> X steps 0..7 with 2 cycles each (16 cycles En=1). Then X=0, En=0, busy=0, done=1 for 1 cycle only.
- Dwell zero (dwell=0, mode=1): behaves as dwell=1 -> 8 cycles of En=1, X=0..7, then done.
- Stop and start/stop collision:
  - stop at X=4 mid-dwell -> next cycle IDLE, X=0, En=0, no done.
  - start+stop in the same IDLE cycle -> stays IDLE.
  - start while busy -> no restart; X continues its sequence.
- SCAN_BLANK_EN (dwell=2, mode=0): pattern is X=0 En=1 x2, X=1 En=0 x1, X=1 En=1 x2, ...; the wrap shows X=0 En=0 for 1 cycle. Period is 24 cycles.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// Shared constants and state encoding for the 3-to-8 decoder scan driver.
package decoder_scan_pkg;

  localparam int SEL_W = 3;
  localparam int NUM_SEL = 8;
  localparam logic [SEL_W-1:0] LAST_SEL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/decoder_scan_driver_dwell_timer.sv
// Down counter timing the dwell of one select; expire is high while the count is 0.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_value,
  input  logic               enable,
  output logic               expire
);

  logic [DWELL_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - DWELL_W'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/decoder_scan_driver.sv
// Scans the decoder select X through 0..7 with a programmable dwell, continuous or single sweep.
// Define SCAN_BLANK_EN to insert a one-cycle En=0 blank at every select change.
module decoder_scan_driver
  import decoder_scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   X,
  output logic               En,
  output logic               busy,
  output logic               done
);

  scan_state_e        state_q, state_d;
  logic [SEL_W-1:0]   x_d;
  logic               en_d, busy_d, done_d;
  logic               mode_q;
  logic [DWELL_W-1:0] dwell_m1_q;
  logic               latch;
  logic               tmr_load, tmr_enable, tmr_expire;
  logic [DWELL_W-1:0] tmr_value;

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (tmr_load),
    .load_value(tmr_value),
    .enable    (tmr_enable),
    .expire    (tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      X          <= '0;
      En         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mode_q     <= 1'b0;
      dwell_m1_q <= '0;
    end else begin
      state_q <= state_d;
      X       <= x_d;
      En      <= en_d;
      busy    <= busy_d;
      done    <= done_d;
      if (latch) begin
        mode_q     <= mode;
        dwell_m1_q <= (dwell == '0) ? '0 : dwell - DWELL_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    x_d        = X;
    en_d       = En;
    busy_d     = busy;
    done_d     = 1'b0;
    latch      = 1'b0;
    tmr_load   = 1'b0;
    tmr_enable = 1'b0;
    tmr_value  = dwell_m1_q;

    case (state_q)
      ST_IDLE: begin
        x_d    = '0;
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start && !stop) begin
          state_d   = ST_ACTIVE;
          en_d      = 1'b1;
          busy_d    = 1'b1;
          latch     = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        end
      end
      ST_ACTIVE: begin
        tmr_enable = 1'b1;
        if (stop) begin
          state_d = ST_IDLE;
          x_d     = '0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (tmr_expire) begin
          if ((X == LAST_SEL) && mode_q) begin
            state_d = ST_IDLE;
            x_d     = '0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // 3-bit increment wraps 7 -> 0 for continuous mode
            x_d      = X + SEL_W'(1);
            tmr_load = 1'b1;
`ifdef SCAN_BLANK_EN
            state_d = ST_BLANK;
            en_d    = 1'b0;
`else
            state_d = ST_ACTIVE;
            en_d    = 1'b1;
`endif
          end
        end
      end
      ST_BLANK: begin
        if (stop) begin
          state_d = ST_IDLE;
          x_d     = '0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_ACTIVE;
          en_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        x_d     = '0;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
